// File: rtl/ps2_pkg.sv
// ps2_pkg: set-2 prefix/scan-code constants and handshake state type
package ps2_pkg;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT   = 8'hAA;
  localparam logic [7:0] PS2_ERR0  = 8'h00;
  localparam logic [7:0] PS2_ERRF  = 8'hFF;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  typedef enum logic {IDLE, ACK} state_t;
endpackage

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut: set-2 scan code to ASCII for letters, digits, space and enter
module ps2_ascii_lut (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);
  logic [7:0] lc;
  always_comb begin
    case (code)
      8'h1C: lc = "a";
      8'h32: lc = "b";
      8'h21: lc = "c";
      8'h23: lc = "d";
      8'h24: lc = "e";
      8'h2B: lc = "f";
      8'h34: lc = "g";
      8'h33: lc = "h";
      8'h43: lc = "i";
      8'h3B: lc = "j";
      8'h42: lc = "k";
      8'h4B: lc = "l";
      8'h3A: lc = "m";
      8'h31: lc = "n";
      8'h44: lc = "o";
      8'h4D: lc = "p";
      8'h15: lc = "q";
      8'h2D: lc = "r";
      8'h1B: lc = "s";
      8'h2C: lc = "t";
      8'h3C: lc = "u";
      8'h2A: lc = "v";
      8'h1D: lc = "w";
      8'h22: lc = "x";
      8'h35: lc = "y";
      8'h1A: lc = "z";
      8'h45: lc = "0";
      8'h16: lc = "1";
      8'h1E: lc = "2";
      8'h26: lc = "3";
      8'h25: lc = "4";
      8'h2E: lc = "5";
      8'h36: lc = "6";
      8'h3D: lc = "7";
      8'h3E: lc = "8";
      8'h46: lc = "9";
      8'h29: lc = 8'h20;
      8'h5A: lc = 8'h0D;
      default: lc = 8'h00;
    endcase
    ascii = (shift && lc >= "a" && lc <= "z") ? lc - 8'h20 : lc;
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: drains the ps2_keyboard FIFO and turns set-2 byte
// sequences into registered key events with held/shift/ASCII tracking
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int E1_SKIP = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       ps2_data_in,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_press,
  output logic             key_repeat,
  output logic [7:0]       key_ascii,
  output logic             shift_held,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_sticky,
  input  logic             clr
);
  localparam int SKIP_W = $clog2(E1_SKIP + 1);
  state_t state;
  logic ext_pend, brk_pend, held_valid, l_sh, r_sh, ovf_q;
  logic [8:0] held_id, id;
  logic [SKIP_W-1:0] skip_cnt;
  logic [7:0] lut_ascii;
  logic capture, is_err, is_pfx, is_key, same, cnt_evt, ovf_rise;
  assign capture    = state == IDLE && ps2_ready;
  assign is_err     = ps2_data_in inside {PS2_ERR0, PS2_ERRF, PS2_BAT};
  assign is_pfx     = ps2_data_in inside {PS2_EXT, PS2_BRK, PS2_PAUSE};
  assign is_key     = capture && skip_cnt == '0 && !is_err && !is_pfx;
  assign id         = {ext_pend, ps2_data_in};
  assign same       = held_valid && id == held_id;
  assign cnt_evt    = is_key && !brk_pend && !same;
  assign ovf_rise   = ps2_overflow && !ovf_q;
  assign shift_held = l_sh | r_sh;
  ps2_ascii_lut u_lut (.code(ps2_data_in), .shift(shift_held), .ascii(lut_ascii));
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state      <= IDLE;
      nextdata_n <= 1'b1;
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_ext    <= 1'b0;
      key_press  <= 1'b0;
      key_repeat <= 1'b0;
      key_ascii  <= '0;
      l_sh       <= 1'b0;
      r_sh       <= 1'b0;
      press_cnt  <= '0;
      ovf_sticky <= 1'b0;
      ovf_q      <= 1'b0;
      held_valid <= 1'b0;
      held_id    <= '0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      skip_cnt   <= '0;
    end else begin
      key_valid <= 1'b0;
      ovf_q     <= ps2_overflow;
      if (capture) begin
        state      <= ACK;
        nextdata_n <= 1'b0;
        if (skip_cnt != '0)
          skip_cnt <= skip_cnt - SKIP_W'(1);
        else if (ps2_data_in == PS2_PAUSE) begin
          skip_cnt <= SKIP_W'(E1_SKIP);
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end else if (ps2_data_in == PS2_EXT)
          ext_pend <= 1'b1;
        else if (ps2_data_in == PS2_BRK)
          brk_pend <= 1'b1;
        else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
        if (is_key) begin
          key_valid  <= 1'b1;
          key_code   <= ps2_data_in;
          key_ext    <= ext_pend;
          key_press  <= !brk_pend;
          key_repeat <= !brk_pend && same;
          key_ascii  <= (!brk_pend && !ext_pend) ? lut_ascii : '0;
          if (!brk_pend) begin
            held_id    <= id;
            held_valid <= 1'b1;
          end else if (same)
            held_valid <= 1'b0;
          if (!ext_pend && ps2_data_in == SC_LSHIFT) l_sh <= !brk_pend;
          if (!ext_pend && ps2_data_in == SC_RSHIFT) r_sh <= !brk_pend;
        end
      end else begin
        state      <= IDLE;
        nextdata_n <= 1'b1;
      end
      // an overflow means the byte stream is broken, so any partial sequence is dropped
      if (ovf_rise) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
        skip_cnt <= '0;
      end
      ovf_sticky <= ovf_rise | (ovf_sticky & ~clr);
      press_cnt  <= clr ? CNT_W'(cnt_evt) : press_cnt + CNT_W'(cnt_evt);
    end
endmodule
